// File: rtl/irq_sequencer_pkg.sv
// Shared definitions for the interrupt sequencer: FSM encoding, default vector
// layout and the vector address helper.
package irq_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_TAKE    = 2'd2,
    ST_SERVICE = 2'd3
  } state_e;

  localparam logic [31:0] DEF_VEC_BASE   = 32'h0000_0100;
  localparam logic [31:0] DEF_VEC_STRIDE = 32'd4;

  // Product is truncated to 32 bits, so vector addresses wrap modulo 2^32.
  function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                           input logic [31:0] stride,
                                           input logic [31:0] idx);
    return base + idx * stride;
  endfunction

endpackage

// File: rtl/irq_sequencer_rr_arbiter.sv
// Combinational round-robin pick: first set request bit searching cyclically
// from last_grant+1.
module rr_arbiter #(
  parameter int N = 8
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] last_grant_i,
  output logic                 gnt_valid_o,
  output logic [$clog2(N)-1:0] gnt_idx_o
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    idx         = '0;
    for (int k = N; k >= 1; k--) begin
      idx = IW'((int'(last_grant_i) + k) % N);
      if (req_i[idx]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = idx;
      end
    end
  end

endmodule

// File: rtl/irq_sequencer.sv
// Non-nesting interrupt sequencer: latches request edges, arbitrates round-robin,
// forces one PC load to the vector at an instruction boundary and holds the return PC.
module irq_sequencer
  import irq_sequencer_pkg::*;
#(
  parameter int          N_IRQ      = 8,
  parameter logic [31:0] VEC_BASE   = DEF_VEC_BASE,
  parameter logic [31:0] VEC_STRIDE = DEF_VEC_STRIDE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_IRQ-1:0]         irq_in,
  input  logic                     irq_en,
  input  logic                     mask_we,
  input  logic [N_IRQ-1:0]         mask_wdata,
  input  logic                     inst_bound,
  input  logic                     enable_pc,
  input  logic                     retirq,
  input  logic [31:0]              pc,
  output logic                     take_req,
  output logic                     irr,
  output logic [31:0]              irr_dest,
  output logic [31:0]              irr_ret,
  output logic                     irq_active,
  output logic [$clog2(N_IRQ)-1:0] irq_id,
  output logic [N_IRQ-1:0]         irq_ack,
  output logic [N_IRQ-1:0]         mask
);

  localparam int IW = $clog2(N_IRQ);

  state_e           state_q, state_d;
  logic [IW-1:0]    irq_id_q, irq_id_d;
  logic [IW-1:0]    last_grant_q, last_grant_d;
  logic [31:0]      irr_ret_q, irr_ret_d;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] ack_q, ack_d;
  logic [N_IRQ-1:0] irq_prev_q;
  logic [N_IRQ-1:0] mask_q;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] eligible;
  logic             gnt_valid;
  logic [IW-1:0]    gnt_idx;

  assign rise     = irq_in & ~irq_prev_q;
  assign eligible = pending_q & mask_q & {N_IRQ{irq_en}};

  rr_arbiter #(.N(N_IRQ)) u_arb (
    .req_i        (eligible),
    .last_grant_i (last_grant_q),
    .gnt_valid_o  (gnt_valid),
    .gnt_idx_o    (gnt_idx)
  );

  always_comb begin
    state_d      = state_q;
    irq_id_d     = irq_id_q;
    last_grant_d = last_grant_q;
    irr_ret_d    = irr_ret_q;
    ack_d        = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          irq_id_d = gnt_idx;
          state_d  = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (!(pending_q[irq_id_q] && mask_q[irq_id_q]) || !irq_en) state_d = ST_IDLE;
        else if (inst_bound)                                          state_d = ST_TAKE;
      end
      // Committed: mask and enable are no longer consulted here.
      ST_TAKE: begin
        if (enable_pc) begin
          irr_ret_d       = pc;
          ack_d[irq_id_q] = 1'b1;
          last_grant_d    = irq_id_q;
          state_d         = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (enable_pc && retirq) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A fresh edge in the ack cycle outranks the clear.
    pending_d = (pending_q & ~ack_d) | rise;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (!rst) begin
      state_q      <= ST_IDLE;
      irq_id_q     <= '0;
      last_grant_q <= IW'(N_IRQ - 1);
      irr_ret_q    <= '0;
      pending_q    <= '0;
      ack_q        <= '0;
      irq_prev_q   <= '0;
      mask_q       <= '0;
    end else begin
      state_q      <= state_d;
      irq_id_q     <= irq_id_d;
      last_grant_q <= last_grant_d;
      irr_ret_q    <= irr_ret_d;
      pending_q    <= pending_d;
      ack_q        <= ack_d;
      irq_prev_q   <= irq_in;
      if (mask_we) mask_q <= mask_wdata;
    end
  end

  assign take_req   = (state_q == ST_TAKE);
  assign irr        = (state_q == ST_TAKE);
  assign irr_dest   = irr ? vec_addr(VEC_BASE, VEC_STRIDE, 32'(irq_id_q)) : '0;
  assign irq_active = (state_q == ST_SERVICE);
  assign irq_id     = irq_id_q;
  assign irq_ack    = ack_q;
  assign irr_ret    = irr_ret_q;
  assign mask       = mask_q;

endmodule

// File: tb/tb_irq_sequencer.sv
// Scoreboard bench for irq_sequencer: each raised request queues its expected
// vector/return PC; a monitor checks irr and irq_ack against the queue head.
module tb_irq_sequencer;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic [N-1:0] irq_in;
  logic         irq_en;
  logic         mask_we;
  logic [N-1:0] mask_wdata;
  logic         inst_bound;
  logic         enable_pc;
  logic         retirq;
  logic [31:0]  pc;
  logic         take_req;
  logic         irr;
  logic [31:0]  irr_dest;
  logic [31:0]  irr_ret;
  logic         irq_active;
  logic [2:0]   irq_id;
  logic [N-1:0] irq_ack;
  logic [N-1:0] mask;

  irq_sequencer #(.N_IRQ(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .irq_in     (irq_in),
    .irq_en     (irq_en),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .inst_bound (inst_bound),
    .enable_pc  (enable_pc),
    .retirq     (retirq),
    .pc         (pc),
    .take_req   (take_req),
    .irr        (irr),
    .irr_dest   (irr_dest),
    .irr_ret    (irr_ret),
    .irq_active (irq_active),
    .irq_id     (irq_id),
    .irq_ack    (irq_ack),
    .mask       (mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          line;
    logic [31:0] dest;
    logic [31:0] ret;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic irr_seen = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] vec(input int line);
    return 32'h100 + 32'(line) * 32'd4;
  endfunction

  task automatic expect_irq(input int line, input logic [31:0] ret);
    exp_t e;
    e.line = line;
    e.dest = vec(line);
    e.ret  = ret;
    sb.push_back(e);
  endtask

  // Monitor samples on the falling edge, away from the active edge.
  always @(negedge clk) begin : mon
    exp_t e;
    if (irr && !irr_seen) begin
      if (sb.size() == 0) check("irr_unexpected", {31'b0, irr}, 32'd0);
      else begin
        check("irr_dest", irr_dest, sb[0].dest);
        check("irr_id", {29'b0, irq_id}, 32'(sb[0].line));
      end
    end
    irr_seen = irr;
    if (irq_ack != '0) begin
      if (sb.size() == 0) check("ack_unexpected", {24'b0, irq_ack}, 32'd0);
      else begin
        e = sb.pop_front();
        check("irq_ack", {24'b0, irq_ack}, 32'd1 << e.line);
        check("irr_ret", irr_ret, e.ret);
        check("ack_id", {29'b0, irq_id}, 32'(e.line));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_mask(input logic [N-1:0] m);
    mask_we    = 1'b1;
    mask_wdata = m;
    step();
    mask_we    = 1'b0;
    check("mask", {24'b0, mask}, {24'b0, m});
  endtask

  task automatic wait_irr(input int max);
    for (int i = 0; i < max && !irr; i++) step();
    check("irr_wait", {31'b0, irr}, 32'd1);
  endtask

  task automatic take(input logic [31:0] pcv);
    wait_irr(20);
    pc        = pcv;
    enable_pc = 1'b1;
    step();
    enable_pc = 1'b0;
    check("active", {31'b0, irq_active}, 32'd1);
    check("dest_in_service", irr_dest, 32'd0);
  endtask

  task automatic retire();
    enable_pc = 1'b1;
    retirq    = 1'b1;
    step();
    enable_pc = 1'b0;
    retirq    = 1'b0;
    check("active_fall", {31'b0, irq_active}, 32'd0);
  endtask

  task automatic do_reset();
    rst    = 1'b0;
    irq_in = '0;
    step();
    rst = 1'b1;
    write_mask(8'hFF);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_take_req"}, {31'b0, take_req}, 32'd0);
    check({tag, "_irr"}, {31'b0, irr}, 32'd0);
    check({tag, "_active"}, {31'b0, irq_active}, 32'd0);
    check({tag, "_id"}, {29'b0, irq_id}, 32'd0);
    check({tag, "_ack"}, {24'b0, irq_ack}, 32'd0);
    check({tag, "_mask"}, {24'b0, mask}, 32'd0);
    check({tag, "_dest"}, irr_dest, 32'd0);
    check({tag, "_ret"}, irr_ret, 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; irq_in = '0; irq_en = 1'b1; mask_we = 1'b0; mask_wdata = '0;
    inst_bound = 1'b1; enable_pc = 1'b0; retirq = 1'b0; pc = '0;
    step(); step();
    check_all_zero("reset");
    rst = 1'b1;
    write_mask(8'hFF);

    // Single line, minimum latency and vector for line 3.
    irq_in[3] = 1'b1;
    expect_irq(3, 32'h40);
    step(); step();
    check("latency_2", {31'b0, irr}, 32'd0);
    step();
    check("latency_3", {31'b0, irr}, 32'd1);
    check("take_req", {31'b0, take_req}, 32'd1);
    take(32'h40);
    retire();

    // Simultaneous lines 1 and 5 from reset: line 1 first.
    do_reset();
    irq_in[1] = 1'b1; irq_in[5] = 1'b1;
    expect_irq(1, 32'h200);
    expect_irq(5, 32'h204);
    take(32'h200); retire();
    take(32'h204); retire();

    // last_grant is 5: line 6 precedes line 2.
    irq_in = '0; step();
    irq_in[2] = 1'b1; irq_in[6] = 1'b1;
    expect_irq(6, 32'h300);
    expect_irq(2, 32'h304);
    take(32'h300); retire();
    take(32'h304); retire();

    // Request during service waits for RETIRQ.
    irq_in = '0; step();
    irq_in[0] = 1'b1;
    expect_irq(0, 32'h400);
    take(32'h400);
    irq_in[2] = 1'b1;
    expect_irq(2, 32'h404);
    repeat (5) step();
    check("no_nesting", {31'b0, irr}, 32'd0);
    retire();
    take(32'h404); retire();

    // Masking in ARMED drops back to IDLE; inst_bound=0 holds ARMED.
    irq_in = '0; inst_bound = 1'b0; step();
    irq_in[4] = 1'b1;
    repeat (4) step();
    check("armed_no_bound", {31'b0, irr}, 32'd0);
    write_mask(8'hEF);
    inst_bound = 1'b1;
    repeat (4) step();
    check("masked_no_irr", {31'b0, irr}, 32'd0);
    inst_bound = 1'b0;
    write_mask(8'hFF);
    repeat (4) step();
    check("unmasked_held", {31'b0, irr}, 32'd0);
    expect_irq(4, 32'h500);
    inst_bound = 1'b1;
    step();
    check("armed_to_take", {31'b0, irr}, 32'd1);
    take(32'h500); retire();

    // Reset during service abandons it and clears pending.
    irq_in = '0; step();
    irq_in[7] = 1'b1;
    expect_irq(7, 32'h600);
    take(32'h600);
    irq_in[1] = 1'b1;
    step();
    rst = 1'b0; irq_in = '0;
    step();
    check_all_zero("midrst");
    rst = 1'b1;
    write_mask(8'hFF);
    repeat (6) step();
    check("pending_cleared", {31'b0, irr}, 32'd0);

    // After reset line 0 wins over line 7.
    irq_in[0] = 1'b1; irq_in[7] = 1'b1;
    expect_irq(0, 32'h700);
    expect_irq(7, 32'h704);
    take(32'h700); retire();
    take(32'h704); retire();

    // New edge on the ack cycle of the same line keeps it pending.
    irq_in = '0; step();
    irq_in[3] = 1'b1;
    expect_irq(3, 32'h800);
    wait_irr(20);
    irq_in[3] = 1'b0;
    step();
    irq_in[3] = 1'b1;
    pc = 32'h800; enable_pc = 1'b1;
    step();
    enable_pc = 1'b0;
    expect_irq(3, 32'h900);
    retire();
    take(32'h900); retire();

    repeat (6) step();
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
